dhcp_vlg_lease: RTL and testbench

//  Lease scheduler sequencing the DHCP engine: issues acquire/renew/rebind requests and tracks lease time.

---
 rtl/dhcp_vlg_pkg.sv | 22 ++
 rtl/dhcp_vlg_sec_tick.sv | 27 ++
 rtl/dhcp_vlg_lease.sv | 167 ++++++++++++++++
 tb/tb_dhcp_vlg_lease.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dhcp_vlg_pkg.sv
// Shared DHCP types: exchange modes requested from the engine and lease scheduler states.
package dhcp_vlg_pkg;

  typedef enum logic [1:0] {
    MODE_DISCOVER = 2'd0,
    MODE_RENEW    = 2'd1,
    MODE_REBIND   = 2'd2
  } dhcp_mode_t;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAcquire = 3'd1,
    StBound   = 3'd2,
    StRenew   = 3'd3,
    StRebind  = 3'd4,
    StBackoff = 3'd5
  } lease_state_t;

  localparam logic [31:0] LEASE_INFINITE = 32'hFFFF_FFFF;
  localparam logic [31:0] ELAPSED_MAX    = 32'hFFFF_FFFE;

endpackage

// File: rtl/dhcp_vlg_sec_tick.sv
// Free-running seconds prescaler: counts 0..TICKS_PER_SEC-1 and pulses tick_o on the wrap cycle.
module dhcp_vlg_sec_tick #(
  parameter int unsigned TICKS_PER_SEC = 125000000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICKS_PER_SEC - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/dhcp_vlg_lease.sv
// Lease scheduler: drives DHCP acquire/renew/rebind exchanges, tracks lease seconds,
// retries failed exchanges with backoff and drops the address on expiry.
module dhcp_vlg_lease
  import dhcp_vlg_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 125000000,
  parameter int unsigned BACKOFF_INIT  = 4,
  parameter int unsigned BACKOFF_MAX   = 64,
  parameter int unsigned ENABLE        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         req,
  output dhcp_mode_t   req_mode,
  input  logic         busy,
  input  logic         done,
  input  logic         ok,
  input  logic [31:0]  lease_sec,
  output logic         ip_valid,
  output lease_state_t state_o,
  output logic [31:0]  remain_sec
);

  localparam logic [31:0] BoInit = 32'(BACKOFF_INIT);
  localparam logic [31:0] BoMax  = 32'(BACKOFF_MAX);

  lease_state_t state_q;
  dhcp_mode_t   req_mode_q, pend_mode_q;
  logic         req_q, ip_valid_q, pend_q, out_q, retry_q, inf_q;
  logic [31:0]  elapsed_q, remain_q, t1_q, t2_q, backoff_q, bo_cnt_q;
  logic         tick, run_en, load, expire, fire;
  logic [31:0]  ls_eff;

  dhcp_vlg_sec_tick #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_tick (
    .clk_i (clk),
    .rst_i (rst),
    .tick_o(tick)
  );

  assign run_en = en && (ENABLE != 0);
  assign ls_eff = (lease_sec == '0) ? 32'd1 : lease_sec;
  assign load   = done && ok && (state_q inside {StAcquire, StRenew, StRebind});
  assign expire = (state_q inside {StRenew, StRebind}) && (elapsed_q >= remain_q);
  // out_q marks an exchange awaiting its done; a queued request waits for it and for busy low.
  assign fire   = pend_q && !busy && !out_q && !done && !expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      req_mode_q  <= MODE_DISCOVER;
      ip_valid_q  <= 1'b0;
      elapsed_q   <= '0;
      remain_q    <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      inf_q       <= 1'b0;
      backoff_q   <= BoInit;
      bo_cnt_q    <= '0;
      retry_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_mode_q <= MODE_DISCOVER;
      out_q       <= 1'b0;
    end else if (!run_en) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      ip_valid_q <= 1'b0;
      backoff_q  <= BoInit;
      retry_q    <= 1'b0;
      pend_q     <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      req_q <= 1'b0;
      if (done) out_q <= 1'b0;
      if (fire) begin
        req_q      <= 1'b1;
        req_mode_q <= pend_mode_q;
        pend_q     <= 1'b0;
        out_q      <= 1'b1;
      end
      if (tick && !inf_q && (elapsed_q != ELAPSED_MAX) &&
          (state_q inside {StBound, StRenew, StRebind})) begin
        elapsed_q <= elapsed_q + 32'd1;
      end
      // A successful done beats a same-cycle t2 or expiry tick.
      if (load) begin
        remain_q   <= ls_eff;
        t1_q       <= ls_eff >> 1;
        t2_q       <= ls_eff - (ls_eff >> 3);
        inf_q      <= (ls_eff == LEASE_INFINITE);
        elapsed_q  <= '0;
        ip_valid_q <= 1'b1;
        backoff_q  <= BoInit;
        retry_q    <= 1'b0;
        pend_q     <= 1'b0;
        state_q    <= StBound;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!busy) begin
              req_q      <= 1'b1;
              req_mode_q <= MODE_DISCOVER;
              out_q      <= 1'b1;
              state_q    <= StAcquire;
            end
          end
          StAcquire: begin
            if (done) begin
              bo_cnt_q  <= backoff_q;
              backoff_q <= (backoff_q >= (BoMax >> 1)) ? BoMax : (backoff_q << 1);
              state_q   <= StBackoff;
            end
          end
          StBackoff: begin
            if (tick) begin
              if (bo_cnt_q <= 32'd1) state_q <= StIdle;
              else bo_cnt_q <= bo_cnt_q - 32'd1;
            end
          end
          StBound: begin
            if (!inf_q && (elapsed_q >= t1_q)) begin
              pend_q      <= 1'b1;
              pend_mode_q <= MODE_RENEW;
              state_q     <= StRenew;
            end
          end
          StRenew, StRebind: begin
            if (expire) begin
              ip_valid_q <= 1'b0;
              pend_q     <= 1'b0;
              retry_q    <= 1'b0;
              out_q      <= 1'b0;
              state_q    <= StIdle;
            end else if ((state_q == StRenew) && (elapsed_q >= t2_q)) begin
              pend_q      <= 1'b1;
              pend_mode_q <= MODE_REBIND;
              retry_q     <= 1'b0;
              state_q     <= StRebind;
            end else if (done) begin
              retry_q  <= 1'b1;
              bo_cnt_q <= BoInit;
            end else if (retry_q && tick) begin
              if (bo_cnt_q <= 32'd1) begin
                retry_q     <= 1'b0;
                pend_q      <= 1'b1;
                pend_mode_q <= (state_q == StRenew) ? MODE_RENEW : MODE_REBIND;
              end else begin
                bo_cnt_q <= bo_cnt_q - 32'd1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign req        = req_q;
  assign req_mode   = req_mode_q;
  assign ip_valid   = ip_valid_q;
  assign state_o    = state_q;
  assign remain_sec = ip_valid_q ? (remain_q - elapsed_q) : '0;

endmodule

// File: tb/tb_dhcp_vlg_lease.sv
// Directed bench for dhcp_vlg_lease: expected requests (mode + cycle window) are queued as
// stimulus is applied and checked when the DUT raises req.
module tb_dhcp_vlg_lease;
  import dhcp_vlg_pkg::*;

  localparam int T = 10;

  logic         clk = 1'b0;
  logic         rst, en, busy, done, ok;
  logic [31:0]  lease_sec;
  logic         req, ip_valid;
  dhcp_mode_t   req_mode;
  lease_state_t state_o;
  logic [31:0]  remain_sec;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int drop_cnt = 0;
  bit watch = 1'b0;

  typedef struct {
    dhcp_mode_t mode;
    int         lo;
    int         hi;
  } exp_t;
  exp_t sbq[$];

  dhcp_vlg_lease #(
    .TICKS_PER_SEC(T),
    .BACKOFF_INIT (4),
    .BACKOFF_MAX  (64),
    .ENABLE       (1)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .req_mode  (req_mode),
    .busy      (busy),
    .done      (done),
    .ok        (ok),
    .lease_sec (lease_sec),
    .ip_valid  (ip_valid),
    .state_o   (state_o),
    .remain_sec(remain_sec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (watch && ip_valid !== 1'b1) drop_cnt <= drop_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input dhcp_mode_t m, input int lo, input int hi);
    exp_t e;
    e.mode = m;
    e.lo   = lo;
    e.hi   = hi;
    sbq.push_back(e);
  endfunction

  // Wait (bounded) for the next req and compare it with the head of the scoreboard.
  task automatic wait_req(input string tag);
    exp_t e;
    int   n = 0;
    int   lim;
    bit   seen = 1'b0;
    e   = sbq.pop_front();
    lim = e.hi - cyc + 10;
    while (!seen && n < lim) begin
      @(negedge clk);
      n++;
      seen = (req === 1'b1);
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_mode"}, 32'(req_mode), 32'(e.mode));
      chk({tag, "_window"}, 32'(cyc >= e.lo && cyc <= e.hi), 32'd1);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    end
  endtask

  // Engine model: busy for lat cycles, then one done pulse; anchor = cycle of the done drive.
  task automatic serve(input int lat, input bit ack, input logic [31:0] ls, output int anchor);
    int extra = 0;
    busy = 1'b1;
    repeat (lat) begin
      @(negedge clk);
      if (req === 1'b1) extra++;
    end
    busy = 1'b0; done = 1'b1; ok = ack; lease_sec = ls; anchor = cyc;
    @(negedge clk);
    if (req === 1'b1) extra++;
    done = 1'b0; ok = 1'b0;
    chk("one_req_per_exchange", 32'(extra), 32'd0);
  endtask

  initial begin
    int r, a, c, p1, p16, d, n, base;
    rst = 1'b1; en = 1'b0; busy = 1'b0; done = 1'b0; ok = 1'b0; lease_sec = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_mode", 32'(req_mode), 32'(MODE_DISCOVER));
    chk("rst_ipv", 32'(ip_valid), 32'd0);
    chk("rst_state", 32'(state_o), 32'(StIdle));
    chk("rst_remain", remain_sec, 32'd0);
    rst = 1'b0; en = 1'b1; r = cyc;

    // 1) lease 8: RENEW at 4 s, REBIND at 7 s, expiry + DISCOVER at 8 s
    push(MODE_DISCOVER, cyc, cyc + 3);
    wait_req("t1_disc");
    serve(2, 1'b1, 32'd8, a);
    chk("t1_ipv", 32'(ip_valid), 32'd1);
    chk("t1_remain", remain_sec, 32'd8);
    chk("t1_state", 32'(state_o), 32'(StBound));
    push(MODE_RENEW,    a + 3*T, a + 4*T + 4);
    push(MODE_REBIND,   a + 6*T, a + 7*T + 4);
    push(MODE_DISCOVER, a + 7*T, a + 8*T + 6);
    wait_req("t1_renew");
    serve(2, 1'b0, 32'd0, c);
    wait_req("t1_rebind");
    chk("t1_rebind_ipv", 32'(ip_valid), 32'd1);
    serve(2, 1'b0, 32'd0, c);
    wait_req("t1_expire_disc");
    chk("t1_expire_ipv", 32'(ip_valid), 32'd0);
    chk("t1_expire_remain", remain_sec, 32'd0);

    // 2) six NACKs: spacing 4,8,16,32,64,64 s
    d = 4;
    for (int i = 0; i < 6; i++) begin
      serve(2, 1'b0, 32'd0, a);
      chk("t2_state", 32'(state_o), 32'(StBackoff));
      push(MODE_DISCOVER, a + (d - 1)*T, a + d*T + 6);
      wait_req("t2_backoff_disc");
      d = (d >= 32) ? 64 : d * 2;
    end

    // 3) lease 100, RENEW acked with 100 -> next RENEW 50 s later, ip_valid never drops
    serve(2, 1'b1, 32'd100, a);
    chk("t3_remain", remain_sec, 32'd100);
    watch = 1'b1;
    base  = drop_cnt;
    push(MODE_RENEW, a + 49*T, a + 50*T + 4);
    wait_req("t3_renew1");
    serve(2, 1'b1, 32'd100, a);
    chk("t3_reload_remain", remain_sec, 32'd100);
    chk("t3_reload_state", 32'(state_o), 32'(StBound));
    push(MODE_RENEW, a + 49*T, a + 50*T + 4);
    wait_req("t3_renew2");
    serve(2, 1'b1, 32'd16, a);

    // 5b) busy held across t1 (8 s): RENEW waits for busy low
    busy = 1'b1; n = 0;
    while (cyc < a + 12*T) begin
      @(negedge clk);
      if (req === 1'b1) n++;
    end
    chk("t5_held_no_req", 32'(n), 32'd0);
    chk("t5_held_state", 32'(state_o), 32'(StRenew));
    busy = 1'b0;
    push(MODE_RENEW, cyc, cyc + 3);
    wait_req("t5_delayed_renew");
    serve(2, 1'b0, 32'd0, c);
    push(MODE_REBIND, a + 13*T, a + 14*T + 4);
    wait_req("t5_rebind");
    // 5a) ACK lands on the 16th tick after load (the expiry tick)
    p1  = a + 2 + ((T - ((a + 2 - r) % T)) % T);
    p16 = p1 + 15*T;
    busy = 1'b1;
    while (cyc < p16 - 1) @(negedge clk);
    busy = 1'b0; done = 1'b1; ok = 1'b1; lease_sec = 32'd20; a = cyc;
    @(negedge clk);
    done = 1'b0; ok = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_state", 32'(state_o), 32'(StBound));
    chk("t5_ipv", 32'(ip_valid), 32'd1);
    chk("t5_remain", remain_sec, 32'd20);
    chk("t35_no_drop", 32'(drop_cnt - base), 32'd0);
    watch = 1'b0;

    // 6) en=0 mid-RENEW, late done ignored, then rst mid-ACQUIRE
    push(MODE_RENEW, a + 9*T, a + 10*T + 4);
    wait_req("t6_renew");
    busy = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_off_ipv", 32'(ip_valid), 32'd0);
    chk("t6_off_state", 32'(state_o), 32'(StIdle));
    chk("t6_off_remain", remain_sec, 32'd0);
    busy = 1'b0; done = 1'b1; ok = 1'b1; lease_sec = 32'd50;
    @(negedge clk);
    done = 1'b0; ok = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_late_done_state", 32'(state_o), 32'(StIdle));
    chk("t6_late_done_ipv", 32'(ip_valid), 32'd0);
    en = 1'b1;
    push(MODE_DISCOVER, cyc, cyc + 3);
    wait_req("t6_reen_disc");
    busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_req", 32'(req), 32'd0);
    chk("t6_rst_mode", 32'(req_mode), 32'(MODE_DISCOVER));
    chk("t6_rst_ipv", 32'(ip_valid), 32'd0);
    chk("t6_rst_state", 32'(state_o), 32'(StIdle));
    chk("t6_rst_remain", remain_sec, 32'd0);
    rst = 1'b0;
    push(MODE_DISCOVER, cyc, cyc + 3);
    wait_req("t6_post_rst_disc");

    // 4) infinite lease: stays BOUND with no requests for 1000 s
    serve(2, 1'b1, 32'hFFFF_FFFF, a);
    chk("t4_remain", remain_sec, 32'hFFFF_FFFF);
    chk("t4_ipv", 32'(ip_valid), 32'd1);
    n = 0;
    repeat (1000 * T) begin
      @(negedge clk);
      if (req === 1'b1) n++;
    end
    chk("t4_no_req", 32'(n), 32'd0);
    chk("t4_state", 32'(state_o), 32'(StBound));
    chk("t4_remain_late", remain_sec, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
